// File: rtl/ext_int_pkg.sv
// Shared constants and types for the external interrupt debounce front end.
package ext_int_pkg;

  localparam int unsigned EXT_INT_NCH            = 4;
  localparam int unsigned EXT_INT_DEB_CYCLES_DEF = 1000000;
  localparam int unsigned EXT_INT_CNT_W          = 20;

  // Which way the debounced level moves at this edge, if at all.
  typedef enum logic [1:0] {
    EdgeNone = 2'b00,
    EdgeRise = 2'b01,
    EdgeFall = 2'b10
  } edge_e;

endpackage

// File: rtl/ext_int_deb_ch.sv
// One channel: 2-flop synchroniser, stability-counter debouncer, registered edge pulses.
// EXT_INT_BOTH_EDGE_EN adds the falling-edge pulse output o_neg.
module ext_int_deb_ch
  import ext_int_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = EXT_INT_DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = EXT_INT_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
`ifdef EXT_INT_BOTH_EDGE_EN
  output logic o_neg,
`endif
  output logic o_pos
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_pos;
  logic [CNT_W-1:0] r_cnt;
  logic             w_done;
  edge_e            w_edge;

  // Level is accepted once sync2 has disagreed with it for DEB_CYCLES edges.
  assign w_done = (r_sync2 != r_level) && (r_cnt == CntLast);

  always_comb begin
    w_edge = EdgeNone;
    if (w_done) begin
      w_edge = r_sync2 ? EdgeRise : EdgeFall;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pos   <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_pos   <= (w_edge == EdgeRise);
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef EXT_INT_BOTH_EDGE_EN
  logic r_neg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_neg <= 1'b0;
    end else begin
      r_neg <= (w_edge == EdgeFall);
    end
  end

  assign o_neg = r_neg;
`endif

  assign o_level = r_level;
  assign o_pos   = r_pos;

endmodule

// File: rtl/ext_int_debounce.sv
// External interrupt front end: N_CH independent debounced channels on sys_clk.
// EXT_INT_BOTH_EDGE_EN adds the four_negedge output.
module ext_int_debounce
  import ext_int_pkg::*;
#(
  parameter int unsigned N_CH       = EXT_INT_NCH,
  parameter int unsigned DEB_CYCLES = EXT_INT_DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = EXT_INT_CNT_W
) (
  input  logic            sys_clk,
  input  logic            sys_reset,
  input  logic [N_CH-1:0] ext_int_in,
`ifdef EXT_INT_BOTH_EDGE_EN
  output logic [N_CH-1:0] four_negedge,
`endif
  output logic [N_CH-1:0] four_posedge,
  output logic [N_CH-1:0] ext_level
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ext_int_deb_ch #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .i_clk  (sys_clk),
      .i_rst  (sys_reset),
      .i_pin  (ext_int_in[g]),
      .o_level(ext_level[g]),
`ifdef EXT_INT_BOTH_EDGE_EN
      .o_neg  (four_negedge[g]),
`endif
      .o_pos  (four_posedge[g])
    );
  end

endmodule

// File: tb/tb_ext_int_debounce.sv
// Bench for ext_int_debounce: DEB_CYCLES=8 and DEB_CYCLES=1 instances against a window-based model.
// EXT_INT_BOTH_EDGE_EN also checks four_negedge.
module tb_ext_int_debounce;

  localparam int unsigned DEB  = 8;
  localparam int          MAXE = 4096;
  localparam int          NM   = 8;  // model channels 0..3 -> dut8, 4..7 -> dut1

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pin = '0;
  logic [3:0] pin1 = '0;
  logic [3:0] pos, lvl, pos1, lvl1;
`ifdef EXT_INT_BOTH_EDGE_EN
  logic [3:0] neg, neg1;
`endif

  always #5 clk = ~clk;

  ext_int_debounce #(.N_CH(4), .DEB_CYCLES(DEB), .CNT_W(20)) dut8 (
    .sys_clk     (clk),
    .sys_reset   (rst),
    .ext_int_in  (pin),
`ifdef EXT_INT_BOTH_EDGE_EN
    .four_negedge(neg),
`endif
    .four_posedge(pos),
    .ext_level   (lvl)
  );

  ext_int_debounce #(.N_CH(4), .DEB_CYCLES(1), .CNT_W(20)) dut1 (
    .sys_clk     (clk),
    .sys_reset   (rst),
    .ext_int_in  (pin1),
`ifdef EXT_INT_BOTH_EDGE_EN
    .four_negedge(neg1),
`endif
    .four_posedge(pos1),
    .ext_level   (lvl1)
  );

  int   n_total = 0;
  int   n_bad   = 0;
  int   e       = 0;  // index of the upcoming rising edge
  logic hist     [NM][MAXE];
  int   last_chg [NM];
  int   last_rst [NM];
  logic m_lvl    [NM];
  logic m_pos    [NM];
  logic m_neg    [NM];
  int   pos0_edge, pos0_cnt, pos10_edge, pos10_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, e, got, exp);
    end
  endtask

  // Pin value seen by the debouncer at edge k: raw pin two edges earlier, zero if a reset intervened.
  function automatic logic seen(int ch, int k);
    if (k - 2 > last_rst[ch]) return hist[ch][k-2];
    return 1'b0;
  endfunction

  // Level flips when the last deb seen values since the previous change all oppose it.
  function automatic logic stable(int ch, int k, int deb);
    if (k - last_chg[ch] < deb) return 1'b0;
    for (int j = 0; j < deb; j++) begin
      if (seen(ch, k - j) == m_lvl[ch]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input logic r, input logic [3:0] p, input logic [3:0] p1);
    logic [3:0] ep, el, ep1, el1, en, en1;
    if (e >= MAXE) begin
      $display("FAIL step_budget at edge %0d: got=%0d expected<%0d", e, e, MAXE);
      $fatal(1);
    end
    @(negedge clk);
    rst  = r;
    pin  = p;
    pin1 = p1;
    for (int c = 0; c < 4; c++) begin
      hist[c][e]   = p[c];
      hist[c+4][e] = p1[c];
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NM; c++) begin
      m_pos[c] = 1'b0;
      m_neg[c] = 1'b0;
      if (r) begin
        m_lvl[c]    = 1'b0;
        last_chg[c] = e;
        last_rst[c] = e;
      end else if (stable(c, e, (c < 4) ? DEB : 1)) begin
        m_lvl[c]    = ~m_lvl[c];
        m_pos[c]    = m_lvl[c];
        m_neg[c]    = ~m_lvl[c];
        last_chg[c] = e;
      end
    end
    for (int c = 0; c < 4; c++) begin
      ep[c]  = m_pos[c];
      el[c]  = m_lvl[c];
      en[c]  = m_neg[c];
      ep1[c] = m_pos[c+4];
      el1[c] = m_lvl[c+4];
      en1[c] = m_neg[c+4];
    end
    check("posedge8", 32'(pos), 32'(ep));
    check("level8", 32'(lvl), 32'(el));
    check("posedge1", 32'(pos1), 32'(ep1));
    check("level1", 32'(lvl1), 32'(el1));
`ifdef EXT_INT_BOTH_EDGE_EN
    check("negedge8", 32'(neg), 32'(en));
    check("negedge1", 32'(neg1), 32'(en1));
`else
    if (en != en1) begin end
`endif
    if (pos[0]) begin
      pos0_edge = e;
      pos0_cnt++;
    end
    if (pos1[0]) begin
      pos10_edge = e;
      pos10_cnt++;
    end
    e++;
  endtask

  initial begin
    int e0;
    logic [3:0] rp, rp1;
    logic       rr;
    for (int c = 0; c < NM; c++) begin
      m_lvl[c]    = 1'b0;
      last_chg[c] = -1;
      last_rst[c] = -1;
    end
    repeat (3) step(1'b1, 4'b0000, 4'b0000);

    // Clean press on ch0 (DEB=8), single-cycle pulse on dut1 ch0 (DEB=1).
    pos0_edge = -1; pos0_cnt = 0; pos10_edge = -1; pos10_cnt = 0;
    e0 = e;
    step(1'b0, 4'b0001, 4'b0001);
    repeat (19) step(1'b0, 4'b0001, 4'b0000);
    check("press_lat", 32'(pos0_edge - e0), 32'd9);
    check("press_cnt", 32'(pos0_cnt), 32'd1);
    check("d1_lat", 32'(pos10_edge - e0), 32'd2);
    check("d1_cnt", 32'(pos10_cnt), 32'd1);

    // Bounce on ch1 while ch0 stays pressed.
    repeat (5) step(1'b0, 4'b0011, 4'b0000);
    repeat (3) step(1'b0, 4'b0001, 4'b0000);
    repeat (6) step(1'b0, 4'b0011, 4'b0000);
    repeat (12) step(1'b0, 4'b0001, 4'b0000);
    check("bounce_lvl", 32'(lvl[1]), 32'd0);

    // Release ch0, then simultaneous press on ch2/ch3.
    repeat (20) step(1'b0, 4'b0000, 4'b0000);
    check("release_lvl", 32'(lvl[0]), 32'd0);
    repeat (20) step(1'b0, 4'b1100, 4'b0000);
    repeat (20) step(1'b0, 4'b0000, 4'b0000);

    // Reset mid-count on ch2 with the pin held high.
    pos0_cnt = 0;
    repeat (7) step(1'b0, 4'b0100, 4'b0000);
    step(1'b1, 4'b0100, 4'b0000);
    check("rst_lvl", 32'(lvl), 32'd0);
    e0 = e;
    repeat (15) step(1'b0, 4'b0100, 4'b0000);
    check("rst_relevel", 32'(lvl[2]), 32'd1);
    repeat (12) step(1'b0, 4'b0000, 4'b0000);

    // Random toggling and occasional resets on both instances.
    rp = '0;
    rp1 = '0;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 9) == 0) rp[c] = ~rp[c];
        if ($urandom_range(0, 2) == 0) rp1[c] = ~rp1[c];
      end
      rr = ($urandom_range(0, 399) == 0);
      step(rr, rp, rp1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
